i2c_target_rx: RTL and testbench

Single-address I2C target (slave) that sits on the same two-wire bus as the team's I2C master controller and answers its transactions. It oversamples SCL/SDA on the system clock, detects START/STOP, matches the 7-bit address, ACKs, and delivers received write bytes to local logic. It also serves read transactions by shifting out bytes supplied by local logic. SDA is driven open-drain through an output-enable.

---
 rtl/i2c_target_rx.sv | 234 +++++++++++++++++++++++
 tb/tb_i2c_target_rx.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_rx.sv
// Single-address I2C target: oversampled SCL/SDA, START/STOP detect, address match, write RX and read TX.
// Latency: bus events acted on 3 clk after the pin change; sda_oe moves 1 clk after a detected SCL fall.
// Backpressure: none; local logic must take rx_data on rx_valid and have tx_data ready for tx_req. Never stretches SCL.
module i2c_target_rx #(
    parameter logic [6:0] SLAVE_ADDR = 7'h12
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_scl_in,
    input  logic       i_sda_in,
    input  logic [7:0] i_tx_data,
    output logic       o_sda_oe,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_tx_req,
    output logic       o_rw,
    output logic       o_busy,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_ADDR_ACK = 3'd2,
        S_RX       = 3'd3,
        S_RX_ACK   = 3'd4,
        S_TX       = 3'd5,
        S_TX_ACK   = 3'd6,
        S_WAIT     = 3'd7
    } state_t;

    // synchronizer and edge-detect flops
    logic r_scl_s1, r_scl_s2, r_scl_d;
    logic r_sda_s1, r_sda_s2, r_sda_d;

    // protocol state
    state_t     r_state, w_state_nxt;
    logic [2:0] r_cnt, w_cnt_nxt;
    logic [6:0] r_shift, w_shift_nxt;     // first 7 bits of the byte being received
    logic [6:0] r_txsh, w_txsh_nxt;       // bits still to be driven after the current one
    logic       r_phase, w_phase_nxt;     // second half of an ACK slot
    logic       r_sda_oe, w_sda_oe_nxt;
    logic [7:0] r_rx_data, w_rx_data_nxt;
    logic       r_rx_valid, w_rx_valid_nxt;
    logic       r_tx_req, w_tx_req_nxt;
    logic       r_rw, w_rw_nxt;
    logic       r_busy, w_busy_nxt;

    logic       w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0] w_byte;

    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_start    = r_scl_s2 & r_sda_d & ~r_sda_s2;
    assign w_stop     = r_scl_s2 & ~r_sda_d & r_sda_s2;
    assign w_byte     = {r_shift, r_sda_s2};

    // bring SCL/SDA into the clock domain and keep one older copy for edge detection
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_scl_s1 <= 1'b0;
            r_scl_s2 <= 1'b0;
            r_scl_d  <= 1'b0;
            r_sda_s1 <= 1'b0;
            r_sda_s2 <= 1'b0;
            r_sda_d  <= 1'b0;
        end else begin
            r_scl_s1 <= i_scl_in;
            r_scl_s2 <= r_scl_s1;
            r_scl_d  <= r_scl_s2;
            r_sda_s1 <= i_sda_in;
            r_sda_s2 <= r_sda_s1;
            r_sda_d  <= r_sda_s2;
        end
    end

    // register the protocol state computed below
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 3'd0;
            r_shift    <= 7'd0;
            r_txsh     <= 7'd0;
            r_phase    <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_tx_req   <= 1'b0;
            r_rw       <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_txsh     <= w_txsh_nxt;
            r_phase    <= w_phase_nxt;
            r_sda_oe   <= w_sda_oe_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_tx_req   <= w_tx_req_nxt;
            r_rw       <= w_rw_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    // next-state: START/STOP override everything, otherwise advance on SCL edges
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_shift_nxt    = r_shift;
        w_txsh_nxt     = r_txsh;
        w_phase_nxt    = r_phase;
        w_sda_oe_nxt   = r_sda_oe;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = 1'b0;
        w_tx_req_nxt   = 1'b0;
        w_rw_nxt       = r_rw;
        w_busy_nxt     = r_busy;

        if (w_start) begin
            w_state_nxt  = S_ADDR;
            w_cnt_nxt    = 3'd0;
            w_phase_nxt  = 1'b0;
            w_sda_oe_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
        end else if (w_stop) begin
            w_state_nxt  = S_IDLE;
            w_cnt_nxt    = 3'd0;
            w_sda_oe_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
        end else begin
            case (r_state)
                S_ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = w_byte[6:0];
                        w_cnt_nxt   = r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            if (w_byte[7:1] == SLAVE_ADDR) begin
                                w_rw_nxt    = w_byte[0];
                                w_busy_nxt  = 1'b1;
                                w_phase_nxt = 1'b0;
                                w_state_nxt = S_ADDR_ACK;
                            end else begin
                                w_state_nxt = S_WAIT;
                            end
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_phase) begin
                            w_sda_oe_nxt = 1'b1;
                            w_phase_nxt  = 1'b1;
                        end else if (!r_rw) begin
                            w_sda_oe_nxt = 1'b0;
                            w_cnt_nxt    = 3'd0;
                            w_state_nxt  = S_RX;
                        end else begin
                            w_txsh_nxt   = i_tx_data[6:0];
                            w_tx_req_nxt = 1'b1;
                            w_sda_oe_nxt = ~i_tx_data[7];
                            w_cnt_nxt    = 3'd0;
                            w_state_nxt  = S_TX;
                        end
                    end
                end
                S_RX: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = w_byte[6:0];
                        w_cnt_nxt   = r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            w_rx_data_nxt  = w_byte;
                            w_rx_valid_nxt = 1'b1;
                            w_phase_nxt    = 1'b0;
                            w_state_nxt    = S_RX_ACK;
                        end
                    end
                end
                S_RX_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_phase) begin
                            w_sda_oe_nxt = 1'b1;
                            w_phase_nxt  = 1'b1;
                        end else begin
                            w_sda_oe_nxt = 1'b0;
                            w_state_nxt  = S_RX;
                        end
                    end
                end
                S_TX: begin
                    if (w_scl_fall) begin
                        if (r_cnt == 3'd7) begin
                            // bit 0 has just been clocked out; hand SDA to the master for ACK
                            w_sda_oe_nxt = 1'b0;
                            w_cnt_nxt    = 3'd0;
                            w_phase_nxt  = 1'b0;
                            w_state_nxt  = S_TX_ACK;
                        end else begin
                            w_sda_oe_nxt = ~r_txsh[6];
                            w_txsh_nxt   = {r_txsh[5:0], 1'b0};
                            w_cnt_nxt    = r_cnt + 3'd1;
                        end
                    end
                end
                S_TX_ACK: begin
                    if (w_scl_rise) begin
                        if (r_sda_s2) w_state_nxt = S_WAIT;
                        else          w_phase_nxt = 1'b1;
                    end else if (w_scl_fall && r_phase) begin
                        w_txsh_nxt   = i_tx_data[6:0];
                        w_tx_req_nxt = 1'b1;
                        w_sda_oe_nxt = ~i_tx_data[7];
                        w_cnt_nxt    = 3'd0;
                        w_state_nxt  = S_TX;
                    end
                end
                S_WAIT: begin
                    w_sda_oe_nxt = 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_sda_oe   = r_sda_oe;
    assign o_rx_data  = r_rx_data;
    assign o_rx_valid = r_rx_valid;
    assign o_tx_req   = r_tx_req;
    assign o_rw       = r_rw;
    assign o_busy     = r_busy;
    assign o_state    = r_state;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: a bit-banged I2C master with a scoreboard on rx_valid and tx_req.
// Expected bytes are queued when issued; a negedge monitor pops and compares them.
// Bus SDA is wired-AND of master drive and target open-drain pull.
module tb_i2c_target_rx;

    localparam logic [6:0] SLAVE = 7'h12;
    localparam int H = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       m_scl, m_sda;
    logic       bus_sda;
    logic [7:0] tx_data;
    logic       o_sda_oe, o_rx_valid, o_tx_req, o_rw, o_busy;
    logic [7:0] o_rx_data;
    logic [2:0] o_state;

    int          vectors = 0;
    int          miscompares = 0;
    int          tx_cnt = 0;
    bit          oe_seen = 0;
    bit          prev_rxv = 0;
    logic [7:0]  exp_rx[$];
    logic [7:0]  byt[4];

    assign bus_sda = m_sda & ~o_sda_oe;

    always #5 clk = ~clk;

    i2c_target_rx #(.SLAVE_ADDR(SLAVE)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_scl_in   (m_scl),
        .i_sda_in   (bus_sda),
        .i_tx_data  (tx_data),
        .o_sda_oe   (o_sda_oe),
        .o_rx_data  (o_rx_data),
        .o_rx_valid (o_rx_valid),
        .o_tx_req   (o_tx_req),
        .o_rw       (o_rw),
        .o_busy     (o_busy),
        .o_state    (o_state)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (o_rx_valid) begin
                if (exp_rx.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rx_unexpected: got %02h expected no byte", o_rx_data);
                end else begin
                    check("rx_data", o_rx_data, exp_rx.pop_front());
                end
                if (prev_rxv) check("rx_valid_width", 2, 1);
            end
            prev_rxv = o_rx_valid;
            if (o_tx_req) tx_cnt++;
            if (o_sda_oe) oe_seen = 1;
        end else begin
            prev_rxv = 0;
        end
    end

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        m_sda = b;
        wclk(H);
        m_scl = 1'b1;
        wclk(H);
        m_scl = 1'b0;
        wclk(1);
    endtask

    task automatic recv_bit(output logic b);
        m_sda = 1'b1;
        wclk(H);
        m_scl = 1'b1;
        wclk(H - 1);
        b = bus_sda;
        wclk(1);
        m_scl = 1'b0;
        wclk(1);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic recv_byte(output logic [7:0] d);
        logic x;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            recv_bit(x);
            d = {d[6:0], x};
        end
    endtask

    task automatic i2c_start();
        m_sda = 1'b0;
        wclk(H);
        m_scl = 1'b0;
        wclk(H);
    endtask

    task automatic i2c_rstart();
        m_sda = 1'b1;
        wclk(H);
        m_scl = 1'b1;
        wclk(H);
        m_sda = 1'b0;
        wclk(H);
        m_scl = 1'b0;
        wclk(1);
    endtask

    task automatic i2c_stop(input bit was_busy);
        m_sda = 1'b0;
        wclk(H);
        m_scl = 1'b1;
        wclk(H);
        m_sda = 1'b1;
        wclk(2);
        if (was_busy) check("busy_before_stop_seen", o_busy, 1);
        wclk(1);
        check("busy_after_stop", o_busy, 0);
        wclk(H);
    endtask

    // one complete transaction; expectations derived from address match and byte list
    task automatic txn(input logic [6:0] a, input logic r, input int n);
        logic       b;
        logic [7:0] got;
        bit         match;
        int         tx0;
        match   = (a == SLAVE);
        oe_seen = 0;
        tx0     = tx_cnt;
        if (r) tx_data = byt[0];
        i2c_start();
        send_byte({a, r}, b);
        check("addr_ack", b, match ? 0 : 1);
        if (!match) begin
            check("state_wait", o_state, 7);
            for (int k = 0; k < n; k++) begin
                send_byte(byt[k], b);
                check("ignored_ack", b, 1);
            end
            check("state_wait_hold", o_state, 7);
        end else if (!r) begin
            check("busy", o_busy, 1);
            check("rw_write", o_rw, 0);
            for (int k = 0; k < n; k++) begin
                exp_rx.push_back(byt[k]);
                send_byte(byt[k], b);
                check("data_ack", b, 0);
            end
        end else begin
            check("rw_read", o_rw, 1);
            for (int k = 0; k < n; k++) begin
                recv_byte(got);
                check("tx_byte", got, byt[k]);
                if (k < n - 1) begin
                    tx_data = byt[k + 1];
                    send_bit(1'b0);
                end else begin
                    send_bit(1'b1);
                end
            end
            check("state_wait_nack", o_state, 7);
        end
        i2c_stop(match);
        check("state_idle", o_state, 0);
        if (!match) check("oe_quiet", oe_seen, 0);
        check("tx_req_count", tx_cnt - tx0, (match && r) ? n : 0);
        check("rx_queue_drained", exp_rx.size(), 0);
    endtask

    initial begin
        logic       b;
        logic [6:0] a;
        rst     = 1'b1;
        m_scl   = 1'b1;
        m_sda   = 1'b1;
        tx_data = 8'h00;
        wclk(3);
        check("rst_sda_oe", o_sda_oe, 0);
        check("rst_rx_data", o_rx_data, 0);
        check("rst_rx_valid", o_rx_valid, 0);
        check("rst_tx_req", o_tx_req, 0);
        check("rst_rw", o_rw, 0);
        check("rst_busy", o_busy, 0);
        check("rst_state", o_state, 0);
        rst = 1'b0;
        wclk(6);

        // directed cases
        byt[0] = 8'hAA;
        txn(7'h12, 1'b0, 1);
        byt[0] = 8'h55;
        txn(7'h2C, 1'b0, 1);
        byt[0] = 8'hAA; byt[1] = 8'h55;
        txn(7'h12, 1'b0, 2);
        byt[0] = 8'hC3; byt[1] = 8'h3C;
        txn(7'h12, 1'b1, 2);

        // repeated START after half a data byte discards the partial byte
        i2c_start();
        send_byte({7'h12, 1'b0}, b);
        check("rs_addr_ack1", b, 0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        i2c_rstart();
        check("rs_state_addr", o_state, 1);
        send_byte({7'h12, 1'b0}, b);
        check("rs_addr_ack2", b, 0);
        exp_rx.push_back(8'h0F);
        send_byte(8'h0F, b);
        check("rs_data_ack", b, 0);
        i2c_stop(1);
        check("rs_rx_drained", exp_rx.size(), 0);

        // reset while the target is pulling SDA for the address ACK
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(i == 0 ? 1'b0 : SLAVE[i - 1]);
        m_sda = 1'b1;
        wclk(H);
        m_scl = 1'b1;
        wclk(2);
        check("pre_reset_ack_oe", o_sda_oe, 1);
        rst = 1'b1;
        #1;
        check("arst_sda_oe", o_sda_oe, 0);
        check("arst_rx_data", o_rx_data, 0);
        check("arst_busy", o_busy, 0);
        check("arst_state", o_state, 0);
        check("arst_rx_valid", o_rx_valid, 0);
        wclk(3);
        rst = 1'b0;
        wclk(8);
        byt[0] = 8'h96;
        txn(7'h12, 1'b0, 1);

        // randomized transactions
        for (int t = 0; t < 14; t++) begin
            if ($urandom_range(0, 2) == 0) begin
                a = 7'($urandom);
                if (a == SLAVE) a = 7'h2C;
            end else begin
                a = SLAVE;
            end
            for (int k = 0; k < 4; k++) byt[k] = 8'($urandom);
            txn(a, 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
